// File: rtl/sa_cache_pkg.sv
// Shared types and constants for the set-associative cache: FSM states,
// replacement policy encodings, word/byte offset widths and a byte-merge helper.
package sa_cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } cache_state_t;

  localparam int REPL_LRU  = 0;
  localparam int REPL_FIFO = 1;

  localparam int WORD_W     = 32;
  localparam int BE_W       = 4;
  localparam int BYTE_OFF_W = 2;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_W; b++) begin
      res[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_cache_repl.sv
// Per-set age ranks and victim selection. Ranks form a permutation per set;
// the highest rank marks the oldest way. LRU ages on hits and fills, FIFO on fills only.
module sa_cache_repl
  import sa_cache_pkg::*;
#(
  parameter int SET_ADDR_LEN = 3,
  parameter int WAY_CNT      = 4,
  parameter int REPLACE      = REPL_LRU,
  localparam int WAY_BITS    = $clog2(WAY_CNT),
  localparam int SETS        = 1 << SET_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SET_ADDR_LEN-1:0] lookup_set,
  input  logic [WAY_CNT-1:0]      lookup_valid,
  output logic [WAY_BITS-1:0]     victim,
  input  logic                    hit_touch,
  input  logic [SET_ADDR_LEN-1:0] hit_set,
  input  logic [WAY_BITS-1:0]     hit_way,
  input  logic                    fill,
  input  logic [SET_ADDR_LEN-1:0] fill_set,
  input  logic [WAY_BITS-1:0]     fill_way
);

  logic [WAY_BITS-1:0]     rank_r [SETS][WAY_CNT];
  logic                    upd_s;
  logic [SET_ADDR_LEN-1:0] upd_set_s;
  logic [WAY_BITS-1:0]     upd_way_s;
  logic [WAY_BITS-1:0]     inv_way_s;
  logic [WAY_BITS-1:0]     old_way_s;

  // Select which access (if any) ages the ranks this cycle.
  always_comb begin
    upd_s     = 1'b0;
    upd_set_s = '0;
    upd_way_s = '0;
    if (fill) begin
      upd_s     = 1'b1;
      upd_set_s = fill_set;
      upd_way_s = fill_way;
    end else if (hit_touch && (REPLACE == REPL_LRU)) begin
      upd_s     = 1'b1;
      upd_set_s = hit_set;
      upd_way_s = hit_way;
    end else begin
      upd_s     = 1'b0;
      upd_set_s = '0;
      upd_way_s = '0;
    end
  end

  // Rank storage: accessed way becomes youngest, younger ways age by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAY_CNT; w++) begin
          rank_r[s][w] <= WAY_BITS'(w);
        end
      end
    end else if (upd_s) begin
      for (int w = 0; w < WAY_CNT; w++) begin
        if (WAY_BITS'(w) == upd_way_s) begin
          rank_r[upd_set_s][w] <= '0;
        end else if (rank_r[upd_set_s][w] < rank_r[upd_set_s][upd_way_s]) begin
          rank_r[upd_set_s][w] <= rank_r[upd_set_s][w] + WAY_BITS'(1);
        end
      end
    end
  end

  // Lowest invalid way wins; with a full set the oldest way is evicted.
  always_comb begin
    inv_way_s = '0;
    old_way_s = '0;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      inv_way_s = lookup_valid[w] ? inv_way_s : WAY_BITS'(w);
      old_way_s = (rank_r[lookup_set][w] == WAY_BITS'(WAY_CNT - 1)) ? WAY_BITS'(w) : old_way_s;
    end
    victim = (&lookup_valid) ? old_way_s : inv_way_s;
  end

endmodule

// File: rtl/sa_cache.sv
// Write-back set-associative cache with a line-based memory handshake.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6,
  parameter int WAY_CNT       = 4,
  parameter int REPLACE       = REPL_LRU,
  localparam int LINE_W       = WORD_W << LINE_ADDR_LEN,
  localparam int MADDR_W      = TAG_ADDR_LEN + SET_ADDR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic               rd_req,
  input  logic               wr_req,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_be,
  output logic [31:0]        rd_data,
  output logic               miss,
  output logic               mem_rd_req,
  output logic               mem_wr_req,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wr_line,
  input  logic [LINE_W-1:0]  mem_rd_line,
  input  logic               mem_gnt
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int WAY_BITS  = $clog2(WAY_CNT);
  localparam int IDX_W     = SET_ADDR_LEN + WAY_BITS;
  localparam int NUM_LINES = 1 << IDX_W;
  localparam int SET_LSB   = BYTE_OFF_W + LINE_ADDR_LEN;
  localparam int TAG_LSB   = SET_LSB + SET_ADDR_LEN;
  localparam int ADDR_USED = TAG_LSB + TAG_ADDR_LEN;

  cache_state_t state_r, next_state_s;

  logic [LINE_W-1:0]       data_mem [NUM_LINES];
  logic [TAG_ADDR_LEN-1:0] tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]    valid_r;
  logic [NUM_LINES-1:0]    dirty_r;

  logic [TAG_ADDR_LEN-1:0]  a_tag_s;
  logic [SET_ADDR_LEN-1:0]  a_set_s;
  logic [LINE_ADDR_LEN-1:0] a_word_s;
  logic                     unused_addr_bits_s;

  logic                    req_s, hit_s, idle_hit_s, miss_edge_s, wr_hit_s, vic_dirty_s;
  logic [WAY_CNT-1:0]      hit_vec_s, set_valid_s;
  logic [WAY_BITS-1:0]     hit_way_s, victim_s;
  logic [IDX_W-1:0]        hit_idx_s, vic_idx_s, fill_idx_s;

  logic [WAY_BITS-1:0]     vic_way_r;
  logic [TAG_ADDR_LEN-1:0] req_tag_r, vic_tag_r;
  logic [SET_ADDR_LEN-1:0] req_set_r;

  assign a_tag_s  = addr[TAG_LSB +: TAG_ADDR_LEN];
  assign a_set_s  = addr[SET_LSB +: SET_ADDR_LEN];
  assign a_word_s = addr[BYTE_OFF_W +: LINE_ADDR_LEN];
  assign unused_addr_bits_s = ^{addr[31:ADDR_USED], addr[BYTE_OFF_W-1:0]};

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_vec_s   = '0;
    set_valid_s = '0;
    hit_way_s   = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      set_valid_s[w] = valid_r[{a_set_s, WAY_BITS'(w)}];
      hit_vec_s[w]   = set_valid_s[w] && (tag_mem[{a_set_s, WAY_BITS'(w)}] == a_tag_s);
      hit_way_s      = hit_vec_s[w] ? WAY_BITS'(w) : hit_way_s;
    end
  end

  assign req_s       = rd_req | wr_req;
  assign hit_s       = |hit_vec_s;
  assign idle_hit_s  = (state_r == IDLE) && req_s && hit_s;
  assign wr_hit_s    = idle_hit_s && wr_req && !rd_req;
  assign miss_edge_s = (state_r == IDLE) && req_s && !hit_s;
  assign miss        = req_s & ~(hit_s & (state_r == IDLE));
  assign hit_idx_s   = {a_set_s, hit_way_s};
  assign vic_idx_s   = {a_set_s, victim_s};
  assign fill_idx_s  = {req_set_r, vic_way_r};
  assign vic_dirty_s = valid_r[vic_idx_s] & dirty_r[vic_idx_s];

  sa_cache_repl #(
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .WAY_CNT      (WAY_CNT),
    .REPLACE      (REPLACE)
  ) u_repl (
    .clk          (clk),
    .rst          (rst),
    .lookup_set   (a_set_s),
    .lookup_valid (set_valid_s),
    .victim       (victim_s),
    .hit_touch    (idle_hit_s),
    .hit_set      (a_set_s),
    .hit_way      (hit_way_s),
    .fill         (state_r == SWAP_IN_OK),
    .fill_set     (req_set_r),
    .fill_way     (vic_way_r)
  );

  // Miss handling sequence; a clean victim skips the write-back.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:       next_state_s = miss_edge_s ? (vic_dirty_s ? SWAP_OUT : SWAP_IN) : IDLE;
      SWAP_OUT:   next_state_s = mem_gnt ? SWAP_IN : SWAP_OUT;
      SWAP_IN:    next_state_s = mem_gnt ? SWAP_IN_OK : SWAP_IN;
      SWAP_IN_OK: next_state_s = IDLE;
      default:    next_state_s = IDLE;
    endcase
  end

  // Memory request decode from the current state.
  always_comb begin
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    case (state_r)
      SWAP_OUT: begin
        mem_wr_req = 1'b1;
        mem_addr   = {vic_tag_r, req_set_r};
      end
      SWAP_IN: begin
        mem_rd_req = 1'b1;
        mem_addr   = {req_tag_r, req_set_r};
      end
      default: begin
        mem_wr_req = 1'b0;
        mem_rd_req = 1'b0;
        mem_addr   = '0;
      end
    endcase
  end

  // State, status bits, read port and miss bookkeeping frozen until IDLE returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      dirty_r     <= '0;
      rd_data     <= 32'd0;
      mem_wr_line <= '0;
      vic_way_r   <= '0;
      req_tag_r   <= '0;
      req_set_r   <= '0;
      vic_tag_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (miss_edge_s) begin
        vic_way_r   <= victim_s;
        req_tag_r   <= a_tag_s;
        req_set_r   <= a_set_s;
        vic_tag_r   <= tag_mem[vic_idx_s];
        mem_wr_line <= data_mem[vic_idx_s];
      end
      if (idle_hit_s && rd_req) begin
        rd_data <= data_mem[hit_idx_s][{a_word_s, 5'd0} +: 32];
      end
      if (wr_hit_s) begin
        dirty_r[hit_idx_s] <= 1'b1;
      end
      if (state_r == SWAP_IN_OK) begin
        valid_r[fill_idx_s] <= 1'b1;
        dirty_r[fill_idx_s] <= 1'b0;
      end
    end
  end

  // Line and tag storage; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (state_r == SWAP_IN_OK) begin
      data_mem[fill_idx_s] <= mem_rd_line;
      tag_mem[fill_idx_s]  <= req_tag_r;
    end else if (wr_hit_s) begin
      data_mem[hit_idx_s][{a_word_s, 5'd0} +: 32] <=
        merge_bytes(data_mem[hit_idx_s][{a_word_s, 5'd0} +: 32], wr_data, wr_be);
    end
  end

`ifdef CACHE_STATS_EN
  // Free-running hit and miss event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (idle_hit_s) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_edge_s) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache: an LRU instance with a latency-programmable memory
// responder and a FIFO instance with an immediate responder share the request inputs.
module tb_sa_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = 32'd0;
  logic         rd_req = 1'b0;
  logic         wr_req = 1'b0;
  logic [31:0]  wr_data = 32'd0;
  logic [3:0]   wr_be = 4'd0;

  logic [31:0]  rd_data0, rd_data1;
  logic         miss0, miss1;
  logic         mem_rd_req0, mem_rd_req1, mem_wr_req0, mem_wr_req1;
  logic [8:0]   mem_addr0, mem_addr1;
  logic [255:0] mem_wr_line0, mem_wr_line1;
  logic [255:0] mem_rd_line0 = 256'd0;
  logic [255:0] mem_rd_line1 = 256'd0;
  logic         mem_gnt0, mem_gnt1;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1;
`endif

  int total = 0;
  int bad = 0;
  int gnt_delay = 0;
  int cnt_w = 0, cnt_r = 0;
  int wr_cyc = 0, rd_cyc = 0, wb_cnt = 0, in_cnt = 0;
  logic [8:0]   wb_addr = 9'd0, in_addr = 9'd0;
  logic [255:0] wb_line = 256'd0;

  always #5 clk = ~clk;

  sa_cache #(.REPLACE(0)) dut0 (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data0), .miss(miss0),
    .mem_rd_req(mem_rd_req0), .mem_wr_req(mem_wr_req0), .mem_addr(mem_addr0),
    .mem_wr_line(mem_wr_line0), .mem_rd_line(mem_rd_line0), .mem_gnt(mem_gnt0)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0)
`endif
  );

  sa_cache #(.REPLACE(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data1), .miss(miss1),
    .mem_rd_req(mem_rd_req1), .mem_wr_req(mem_wr_req1), .mem_addr(mem_addr1),
    .mem_wr_line(mem_wr_line1), .mem_rd_line(mem_rd_line1), .mem_gnt(mem_gnt1)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1)
`endif
  );

  // Memory content: word w of line {tag,set} = {A5A5, w, set, 0, tag}.
  function automatic logic [255:0] pat_line(input logic [8:0] la);
    logic [255:0] l;
    logic [2:0]   wi;
    for (int w = 0; w < 8; w++) begin
      wi = 3'(w);
      l[w*32 +: 32] = {16'hA5A5, wi, la[2:0], 4'h0, la[8:3]};
    end
    return l;
  endfunction

  assign mem_gnt0 = (mem_wr_req0 && (cnt_w >= gnt_delay)) || (mem_rd_req0 && (cnt_r >= gnt_delay));
  assign mem_gnt1 = mem_rd_req1 | mem_wr_req1;

  always @(posedge clk) begin
    cnt_w <= mem_wr_req0 ? cnt_w + 1 : 0;
    cnt_r <= mem_rd_req0 ? cnt_r + 1 : 0;
    if (mem_rd_req0) mem_rd_line0 <= pat_line(mem_addr0);
    if (mem_rd_req1) mem_rd_line1 <= pat_line(mem_addr1);
    if (mem_wr_req0) wr_cyc <= wr_cyc + 1;
    if (mem_rd_req0) rd_cyc <= rd_cyc + 1;
    if (mem_wr_req0 && mem_gnt0) begin
      wb_cnt  <= wb_cnt + 1;
      wb_addr <= mem_addr0;
      wb_line <= mem_wr_line0;
    end
    if (mem_rd_req0 && mem_gnt0) begin
      in_cnt  <= in_cnt + 1;
      in_addr <= mem_addr0;
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One access on both caches, waiting (bounded) for dut0 to stop missing.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic first_miss, output int n);
    @(negedge clk);
    rd_req = r; wr_req = w; addr = a; wr_data = d; wr_be = be;
    #1;
    first_miss = miss0;
    n = 0;
    while (miss0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL access_timeout addr=%0h: got=still_missing expected=hit", a);
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  // Look at miss for a read request without letting it reach a clock edge.
  task automatic probe(input logic [31:0] a, output logic m0, output logic m1);
    @(negedge clk);
    addr = a; rd_req = 1'b1; wr_req = 1'b0;
    #1;
    m0 = miss0;
    m1 = miss1;
    rd_req = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        exp_miss;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic fm, m0, m1;
    int   n, wb0, in0, wr0, rd0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hA5A5_2001};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'h5, 1'b0, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hFF22_FF44};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0108, 32'h1234_5678, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0108, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hA5A5_4001};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_010C, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'hA5A5_6001};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_010C, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hA5A5_6001};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_02A4, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'hA5A5_3402};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_02A7, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hA5A5_3402};
    vecs[10] = '{1'b1, 1'b0, 32'hF000_02A4, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'hA5A5_3402};

    // Reset state.
    do_reset();
    #1;
    check("rst_rd_data", rd_data0, 32'd0);
    check("rst_miss_idle", miss0, 1'b0);
    check("rst_mem_rd_req", mem_rd_req0, 1'b0);
    check("rst_mem_wr_req", mem_wr_req0, 1'b0);
    check("rst_mem_addr", mem_addr0, 9'd0);
    check("rst_mem_wr_line", mem_wr_line0, 256'd0);
    probe(32'h0000_0000, m0, m1);
    check("rst_all_invalid", m0, 1'b1);

    // Cold read miss: single fill, no write-back.
    wb0 = wb_cnt; in0 = in_cnt;
    access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'h0, fm, n);
    check("cold_first_miss", fm, 1'b1);
    check("cold_miss_cycles", n, 3);
    check("cold_swap_in_cnt", in_cnt - in0, 1);
    check("cold_swap_out_cnt", wb_cnt - wb0, 0);
    check("cold_mem_addr", in_addr, 9'h008);
    check("cold_rd_data", rd_data0, 32'hA5A5_0001);

    // Vector table: hits, byte enables, rd+wr priority, byte offset, unused address bits.
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, fm, n);
      check($sformatf("vec%0d_miss", i), fm, vecs[i].exp_miss);
      if (vecs[i].chk) check($sformatf("vec%0d_rd_data", i), rd_data0, vecs[i].exp_rd);
    end

    // Dirty victim with write-back and delayed grants.
    access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0400, 32'd0, 4'h0, fm, n);
    gnt_delay = 5;
    wb0 = wb_cnt; wr0 = wr_cyc; rd0 = rd_cyc;
    access(1'b1, 1'b0, 32'h0000_0500, 32'd0, 4'h0, fm, n);
    gnt_delay = 0;
    check("wb_first_miss", fm, 1'b1);
    check("wb_miss_cycles", n, 14);
    check("wb_swap_out_cycles", wr_cyc - wr0, 6);
    check("wb_swap_in_cycles", rd_cyc - rd0, 6);
    check("wb_count", wb_cnt - wb0, 1);
    check("wb_mem_addr", wb_addr, 9'h008);
    check("wb_word0", wb_line[31:0], 32'hA5A5_0001);
    check("wb_word1", wb_line[63:32], 32'hFF22_FF44);
    check("wb_word2", wb_line[95:64], 32'hA5A5_4001);
    check("wb_fill_addr", in_addr, 9'h028);
    check("wb_rd_data", rd_data0, 32'hA5A5_0005);

    // LRU versus FIFO victim choice.
    do_reset();
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'h0, fm, n);
    check("repl_tag0_hit", fm, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0400, 32'd0, 4'h0, fm, n);
    check("repl_tag4_miss", fm, 1'b1);
    probe(32'h0000_0000, m0, m1);
    check("lru_tag0_kept", m0, 1'b0);
    check("fifo_tag0_evicted", m1, 1'b1);
    probe(32'h0000_0100, m0, m1);
    check("lru_tag1_evicted", m0, 1'b1);
    check("fifo_tag1_kept", m1, 1'b0);

    // Reset in the middle of a fill.
    gnt_delay = 5;
    @(negedge clk);
    addr = 32'h0000_0700; rd_req = 1'b1; wr_req = 1'b0;
    n = 0;
    while (!mem_rd_req0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_swap_in", mem_rd_req0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_mem_rd_req", mem_rd_req0, 1'b0);
    check("abort_mem_addr", mem_addr0, 9'd0);
    check("abort_miss_idle", miss0, 1'b1);
    check("abort_rd_data", rd_data0, 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;
    probe(32'h0000_0700, m0, m1);
    check("abort_same_addr_miss", m0, 1'b1);

`ifdef CACHE_STATS_EN
    do_reset();
    #1;
    check("stats_rst_hit", hit_cnt0, 32'd0);
    check("stats_rst_miss", miss_cnt0, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0004, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0104, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0204, 32'd0, 4'h0, fm, n);
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'h0, fm, n);
    #1;
    check("stats_miss_cnt", miss_cnt0, 32'd3);
    check("stats_hit_cnt", hit_cnt0, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
